// File: rtl/if_id_stage.sv
// Fetch-to-decode boundary: 2-entry skid buffer with the head instruction's fields split out.
// Optional stall/bubble performance counters are built only when IFID_PERF_CNT_EN is defined.
module if_id_stage #(
   parameter int DATA_W   = 32,
   parameter int IMM_SEXT = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              if_valid_i,
   input  logic [DATA_W-1:0] if_pc_i,
   input  logic [DATA_W-1:0] if_inst_i,
   output logic              if_ready_o,
   input  logic              id_ready_i,
   output logic              id_valid_o,
   output logic [DATA_W-1:0] id_pc_o,
   output logic [DATA_W-1:0] id_inst_o,
   output logic [5:0]        id_opcode_o,
   output logic [4:0]        id_rs1_o,
   output logic [4:0]        id_rs2_o,
   output logic [4:0]        id_rd_o,
   output logic [5:0]        id_funct_o,
   output logic [DATA_W-1:0] id_imm_o
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] inst;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

   state_t state, state_nxt;
   entry_t main_q, skid_q, in_e;
   logic   push, pop;
   logic   ld_main, ld_main_skid, ld_skid;
   logic [DATA_W-1:0] head_inst;

   // Ready depends on state alone, so no combinational path from decode back to fetch.
   assign if_ready_o = (state != FULL);
   assign id_valid_o = (state != EMPTY);
   assign push       = if_valid_i && if_ready_o;
   assign pop        = id_valid_o && id_ready_i;
   assign in_e       = {if_pc_i, if_inst_i};

   always_comb begin
      state_nxt    = state;
      ld_main      = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush_i) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (push) begin
               ld_main   = 1'b1;
               state_nxt = HALF;
            end
            HALF: begin
               if (push && pop) begin
                  ld_main = 1'b1;
               end else if (push) begin
                  ld_skid   = 1'b1;
                  state_nxt = FULL;
               end else if (pop) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: if (pop) begin
               ld_main_skid = 1'b1;
               state_nxt    = HALF;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nxt;
         if (ld_main)           main_q <= in_e;
         else if (ld_main_skid) main_q <= skid_q;
         if (ld_skid)           skid_q <= in_e;
      end
   end

   // Zeroing the head once here blanks every derived field while invalid.
   assign head_inst   = id_valid_o ? main_q.inst : '0;
   assign id_pc_o     = id_valid_o ? main_q.pc : '0;
   assign id_inst_o   = head_inst;
   assign id_opcode_o = head_inst[31:26];
   assign id_rs1_o    = head_inst[25:21];
   assign id_rs2_o    = head_inst[20:16];
   assign id_rd_o     = head_inst[15:11];
   assign id_funct_o  = head_inst[5:0];

   generate
      if (IMM_SEXT != 0) begin : g_sext
         assign id_imm_o = {{(DATA_W-16){head_inst[15]}}, head_inst[15:0]};
      end else begin : g_zext
         assign id_imm_o = {{(DATA_W-16){1'b0}}, head_inst[15:0]};
      end
   endgenerate

`ifdef IFID_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   logic [CNT_W-1:0] stall_q, bubble_q;

   // Saturating counters; only reset clears them, flush leaves history intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (id_valid_o && !id_ready_i && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
         if (!id_valid_o && (bubble_q != '1))              bubble_q <= bubble_q + CNT_ONE;
      end
   end

   assign stall_cnt_o  = stall_q;
   assign bubble_cnt_o = bubble_q;
`endif

endmodule
